// File: rtl/bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output in, natural-order frame out.
// Optional OUT_FRAME_FLAGS_EN adds data_out_sof / data_out_eof frame markers.
module bitrev_reorder #(
   parameter int float_len     = 32,
   parameter int bram_addr_len = 13
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [2*float_len-1:0]   data_in,
   input  logic                     data_in_valid,
   output logic [2*float_len-1:0]   data_out,
   output logic                     data_out_valid,
   output logic                     overflow
`ifdef OUT_FRAME_FLAGS_EN
   ,
   output logic                     data_out_sof,
   output logic                     data_out_eof
`endif
);

   localparam int DW = 2 * float_len;
   localparam int AW = bram_addr_len;
   localparam int N  = 1 << AW;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_READ = 1'b1;

   localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

   // Writer state
   logic [AW-1:0]  r_wr_cnt;
   logic           r_wr_bank;
   logic [1:0]     r_bank_full;
   logic [1:0]     w_bank_full_next;
   logic [AW-1:0]  w_wr_rev;
   logic           w_wr_wrap;

   // Reader state
   logic [0:0]     r_state;
   logic           r_rd_bank;
   logic [AW-1:0]  r_rd_cnt;
   logic           w_rd_en;
   logic           w_rd_last;

   // RAM and output pipeline
   logic [DW-1:0]  r_mem [0:2*N-1];
   logic [DW-1:0]  r_rd_data;
   logic           r_rd_vld;
   logic [DW-1:0]  r_dout;
   logic           r_dout_vld;
   logic           r_overflow;

   generate
      for (genvar gi = 0; gi < AW; gi++) begin : g_rev
         assign w_wr_rev[gi] = r_wr_cnt[AW-1-gi];
      end
   endgenerate

   assign w_wr_wrap = data_in_valid && (r_wr_cnt == LAST_IDX);
   assign w_rd_en   = (r_state == S_READ);
   assign w_rd_last = w_rd_en && (r_rd_cnt == LAST_IDX);

   // A wrap onto the bank whose last read is in flight is an overflow; the set wins.
   always_comb begin
      w_bank_full_next = r_bank_full;
      if (w_rd_last)
         w_bank_full_next[r_rd_bank] = 1'b0;
      if (w_wr_wrap)
         w_bank_full_next[r_wr_bank] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_cnt    <= '0;
         r_wr_bank   <= 1'b0;
         r_bank_full <= 2'b00;
         r_overflow  <= 1'b0;
      end else begin
         r_bank_full <= w_bank_full_next;
         if (data_in_valid) begin
            r_wr_cnt <= r_wr_cnt + AW'(1);
            if (w_wr_wrap) begin
               r_wr_bank <= ~r_wr_bank;
               if (r_bank_full[r_wr_bank] || (w_rd_en && (r_rd_bank == r_wr_bank)))
                  r_overflow <= 1'b1;
            end
         end
      end
   end

   // With both banks full the older one is the bank the writer is about to refill.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_rd_bank <= 1'b0;
         r_rd_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_bank_full != 2'b00) begin
                  r_state   <= S_READ;
                  r_rd_cnt  <= '0;
                  r_rd_bank <= (r_bank_full == 2'b11) ? r_wr_bank : r_bank_full[1];
               end
            end
            S_READ: begin
               r_rd_cnt <= r_rd_cnt + AW'(1);
               if (r_rd_cnt == LAST_IDX) begin
                  if (r_bank_full[~r_rd_bank]) begin
                     r_rd_bank <= ~r_rd_bank;
                     r_rd_cnt  <= '0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (data_in_valid && !rst)
         r_mem[{r_wr_bank, w_wr_rev}] <= data_in;
      if (w_rd_en)
         r_rd_data <= r_mem[{r_rd_bank, r_rd_cnt}];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_vld   <= 1'b0;
         r_dout     <= '0;
         r_dout_vld <= 1'b0;
      end else begin
         r_rd_vld   <= w_rd_en;
         r_dout     <= r_rd_vld ? r_rd_data : '0;
         r_dout_vld <= r_rd_vld;
      end
   end

   assign data_out       = r_dout;
   assign data_out_valid = r_dout_vld;
   assign overflow       = r_overflow;

`ifdef OUT_FRAME_FLAGS_EN
   logic r_rd_sof;
   logic r_rd_eof;
   logic r_sof;
   logic r_eof;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_sof <= 1'b0;
         r_rd_eof <= 1'b0;
         r_sof    <= 1'b0;
         r_eof    <= 1'b0;
      end else begin
         r_rd_sof <= w_rd_en && (r_rd_cnt == '0);
         r_rd_eof <= w_rd_last;
         r_sof    <= r_rd_vld && r_rd_sof;
         r_eof    <= r_rd_vld && r_rd_eof;
      end
   end

   assign data_out_sof = r_sof;
   assign data_out_eof = r_eof;
`endif

endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed bench for bitrev_reorder with N=8; expected orders are hand-computed.
module tb_bitrev_reorder;

   localparam int FL = 32;
   localparam int AW = 3;
   localparam int DW = 2 * FL;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] data_in = '0;
   logic          data_in_valid = 1'b0;
   logic [DW-1:0] data_out;
   logic          data_out_valid;
   logic          overflow;
`ifdef OUT_FRAME_FLAGS_EN
   logic          data_out_sof;
   logic          data_out_eof;
`endif

   bitrev_reorder #(.float_len(FL), .bram_addr_len(AW)) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .overflow       (overflow)
`ifdef OUT_FRAME_FLAGS_EN
      ,
      .data_out_sof   (data_out_sof),
      .data_out_eof   (data_out_eof)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_bad   = 0;
   int last_in = 0;
   int n_junk  = 0;

   // natural index n holds input sample bitrev3(n)
   int ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   logic [63:0] q_d [$];
   int          q_c [$];
   bit          q_s [$];
   bit          q_e [$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] smp(input int k);
      logic [31:0] re;
      re = 32'(k);
      return {re, re ^ 32'hA5A5_5A5A};
   endfunction

   always @(negedge clk) begin
      if (data_out_valid === 1'b1) begin
         q_d.push_back(data_out);
         q_c.push_back(cyc);
`ifdef OUT_FRAME_FLAGS_EN
         q_s.push_back(data_out_sof);
         q_e.push_back(data_out_eof);
         $display("out cyc=%0d data=%016h sof=%0b eof=%0b", cyc, data_out, data_out_sof, data_out_eof);
`else
         $display("out cyc=%0d data=%016h", cyc, data_out);
`endif
      end else if (data_out !== '0 && cyc > 0) begin
         n_junk++;
      end
   end

   task automatic clear_q();
      q_d.delete();
      q_c.delete();
      q_s.delete();
      q_e.delete();
   endtask

   task automatic idle(input int n);
      data_in_valid = 1'b0;
      data_in       = '0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Valid is left high after the last sample so consecutive calls abut.
   task automatic send(input int base, input int gap, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         data_in       = smp(base + i);
         data_in_valid = 1'b1;
         @(posedge clk);
         #1;
         last_in = cyc;
         if (gap > 0) idle(gap);
      end
   endtask

   task automatic wait_out(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (q_d.size() < n && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk({tag, "_arrived"}, (q_d.size() >= n), 1);
   endtask

   task automatic check_frame(input string tag, input int base, input int first);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s_d%0d", tag, i), q_d[first + i], smp(base + ord[i]));
         if (i > 0)
            chk($sformatf("%s_gap%0d", tag, i), q_c[first + i] - q_c[first + i - 1], 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", data_out_valid, 0);
      chk("rst_data", data_out, 0);
      chk("rst_ovf", overflow, 0);
      rst = 1'b0;
      idle(2);

      // test 1: single contiguous frame
      clear_q();
      send(0, 0, 8);
      idle(1);
      wait_out("t1", 8, 40);
      chk("t1_latency", q_c[0] - last_in, 3);
      check_frame("t1", 0, 0);
      idle(10);
      chk("t1_count", q_d.size(), 8);

      // test 2: two frames back-to-back
      clear_q();
      send(0, 0, 8);
      send(8, 0, 8);
      idle(1);
      wait_out("t2", 16, 60);
      check_frame("t2a", 0, 0);
      check_frame("t2b", 8, 8);
      chk("t2_join", q_c[8] - q_c[7], 1);
      idle(10);
      chk("t2_count", q_d.size(), 16);
      chk("t2_ovf", overflow, 0);
`ifdef OUT_FRAME_FLAGS_EN
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t6_sof%0d", i), q_s[i], (i % 8) == 0);
         chk($sformatf("t6_eof%0d", i), q_e[i], (i % 8) == 7);
      end
`endif

      // test 3: valid toggling every cycle
      clear_q();
      send(0, 1, 8);
      wait_out("t3", 8, 40);
      chk("t3_latency", q_c[0] - last_in, 3);
      check_frame("t3", 0, 0);
      idle(10);

      // test 4: reset mid-frame discards the partial
      clear_q();
      send(50, 0, 5);
      rst           = 1'b1;
      data_in_valid = 1'b0;
      data_in       = '0;
      @(posedge clk);
      #1;
      chk("t4_rst_valid", data_out_valid, 0);
      chk("t4_rst_data", data_out, 0);
      rst = 1'b0;
      send(100, 0, 8);
      idle(1);
      wait_out("t4", 8, 40);
      chk("t4_latency", q_c[0] - last_in, 3);
      check_frame("t4", 100, 0);
      idle(20);
      chk("t4_count", q_d.size(), 8);
      chk("t4_ovf", overflow, 0);

      // test 5: both banks marked full, then a frame completes
      clear_q();
      force dut.r_bank_full = 2'b11;
      send(200, 0, 8);
      idle(2);
      chk("t5_ovf_set", overflow, 1);
      release dut.r_bank_full;
      idle(40);
      chk("t5_ovf_sticky", overflow, 1);
      rst = 1'b1;
      idle(1);
      chk("t5_ovf_rst", overflow, 0);
      chk("t5_rst_valid", data_out_valid, 0);
      rst = 1'b0;
      idle(3);

      chk("idle_data_zero", n_junk, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
